bin_frame_reader: RTL and testbench
===================================

# bin_frame_reader

Read-back end of the binarization path. After the binarization stage has filled the 1-bit binary image RAM, this block scans the RAM in raster order. It packs 8 pixels per byte, MSB first, and streams the bytes over a valid/ready interface to the host-link transmitter. It drives the RAM read address and consumes the RAM's 1-bit read data. It is started by a level control input that may be held high for several cycles.

## Interface
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in pixels
- ADDR_W, 16, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- rdr_clk  in  1  single clock; all logic on rising edge
- rdr_rst  in  1  reset, synchronous, active-high
- rdr_ctrl  in  1  start request; may stay high many cycles
- pixel_address  out  ADDR_W  binary RAM read address
- bin_data  in  1  RAM read data; valid one cycle after the address is presented
- byte_data  out  8  packed pixels; first-read pixel in bit 7
- byte_valid  out  1  byte_data is valid
- byte_ready  in  1  downstream accepts the byte
- condition_led  out  2  00 idle, 01 busy, 10 done

## Operation
- IMG_W*IMG_H must be a multiple of 8. NBYTES = IMG_W*IMG_H/8.
- Start is the rising edge of rdr_ctrl: a registered previous value was 0 and the current sample is 1.
  - A held-high rdr_ctrl yields exactly one start.
  - A start seen while busy is ignored.
  - A start seen in IDLE or DONE begins a new frame.
- FSM states:
  - IDLE: no fetch activity.
  - FETCH:
    - Issues 8 consecutive addresses, one per cycle.
    - Shifts bin_data into an 8-bit register one cycle after each address: shift left, new bit into bit 0.
    - After the 8th capture, loads byte_data and goes to SEND.
  - SEND:
    - byte_valid = 1; byte_data is held stable until byte_ready is sampled high.
    - On handshake: if this was byte NBYTES-1, go to DONE; otherwise go to FETCH.
  - DONE:
    - condition_led = 10 until the next start or reset.
    - pixel_address holds its last value.
- Addresses run 0 .. IMG_W*IMG_H-1 with no gaps.
- The address counter is ADDR_W wide. It is cleared to 0 on each start and never wraps within a frame.
- Byte counter width is ceil(log2(NBYTES+1)).
- condition_led: 00 after reset, 01 from the first FETCH cycle until the final handshake, 10 in DONE.

## Timing
- Reset values:
  - State = IDLE; pixel_address = 0; byte_data = 0; byte_valid = 0; condition_led = 00.
  - The rdr_ctrl edge register is cleared to 0, so rdr_ctrl high at reset release counts as a start.
- Let S be the cycle in which the start edge is sampled.
  - pixel_address = 0 at S+1, and increments each cycle through S+8 (address 7).
  - bin_data is captured at S+2 .. S+9.
  - byte_valid rises at S+10.
- Handshake:
  - A handshake occurs in any cycle where byte_valid and byte_ready are both high.
  - The next byte's first address appears the cycle after the handshake.
  - Each following byte has valid 10 cycles after the previous handshake.
  - With byte_ready tied high, one byte takes 10 cycles.
- byte_ready is ignored when byte_valid = 0.
- byte_valid is never deasserted without a handshake, except on reset.
- After the final handshake, byte_valid falls next cycle and condition_led = 10 the same next cycle.
- Reset asserted mid-frame: all outputs take their reset values on the next edge. No further bytes are emitted until a new start edge.
- Start edge arriving in the same cycle as the final handshake: ignored.

## Test plan
- Reset check: assert rdr_rst for 3 cycles with rdr_ctrl = 0 -> byte_valid = 0, condition_led = 00, pixel_address = 0; no activity for 20 cycles.
- Pattern pack (IMG_W = 8, IMG_H = 2): RAM model preloaded with bits 10100101 then 00111100, byte_ready = 1, rdr_ctrl pulsed -> bytes 0xA5 then 0x3C; first byte_valid at S+10; condition_led 01 then 10.
- Backpressure: byte_ready held 0 for 5 cycles while byte_valid = 1 -> byte_data and pixel_address stay stable, no extra address issued, still 2 bytes total.
- Held start: rdr_ctrl high for 10 cycles -> exactly one frame (2 bytes); a second edge during busy yields no extra bytes; an edge in DONE starts a new identical frame.
- Full frame (defaults): RAM pixel value = address[3] -> 8192 bytes alternating 0x00 / 0xFF; last address 65535; DONE reached.
- Mid-frame reset: assert rdr_rst while in SEND of byte 1 -> next cycle byte_valid = 0 and condition_led = 00; a new start restarts at address 0.

Source files
------------

// File: rtl/bin_frame_reader.sv
// bin_frame_reader: raster-scans the 1-bit binary image RAM and streams the
// pixels packed 8 per byte (first-read pixel in bit 7) over valid/ready.
module bin_frame_reader #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              rdr_clk,
  input  logic              rdr_rst,
  input  logic              rdr_ctrl,
  output logic [ADDR_W-1:0] pixel_address,
  input  logic              bin_data,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [1:0]        condition_led
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NBYTES = NPIX / 8;
  localparam int BCNT_W = $clog2(NBYTES + 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              ctrl_prev;
  logic              start;
  logic              handshake;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [3:0]        phase, phase_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic [7:0]        data_q, data_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;

  assign start     = rdr_ctrl & ~ctrl_prev;
  assign handshake = (state == SEND) & byte_ready;

  // phase 0..7 present addresses base..base+7; phases 1..8 capture the RAM
  // data, which lags the address by one cycle, so the address holds at phase 8.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    phase_nxt = phase;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = FETCH;
          addr_nxt  = '0;
          phase_nxt = 4'd0;
          shreg_nxt = 8'd0;
          bcnt_nxt  = '0;
        end
      end
      FETCH: begin
        phase_nxt = phase + 4'd1;
        if (phase < 4'd7) begin
          addr_nxt = addr + ADDR_W'(1);
        end
        if (phase != 4'd0) begin
          shreg_nxt = {shreg[6:0], bin_data};
        end
        if (phase == 4'd8) begin
          data_nxt  = {shreg[6:0], bin_data};
          phase_nxt = 4'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (bcnt == LAST_BYTE) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FETCH;
            addr_nxt  = addr + ADDR_W'(1);
            phase_nxt = 4'd0;
            bcnt_nxt  = bcnt + BCNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rdr_clk) begin
    if (rdr_rst) begin
      state     <= IDLE;
      ctrl_prev <= 1'b0;
      addr      <= '0;
      phase     <= 4'd0;
      shreg     <= 8'd0;
      data_q    <= 8'd0;
      bcnt      <= '0;
    end else begin
      state     <= state_nxt;
      ctrl_prev <= rdr_ctrl;
      addr      <= addr_nxt;
      phase     <= phase_nxt;
      shreg     <= shreg_nxt;
      data_q    <= data_nxt;
      bcnt      <= bcnt_nxt;
    end
  end

  always_comb begin
    condition_led = 2'b00;
    case (state)
      FETCH, SEND: condition_led = 2'b01;
      DONE:        condition_led = 2'b10;
      default:     condition_led = 2'b00;
    endcase
  end

  assign byte_valid    = (state == SEND);
  assign byte_data     = data_q;
  assign pixel_address = addr;

endmodule

// File: tb/tb_bin_frame_reader.sv
// tb_bin_frame_reader: table, hand-sequence and randomized checks on an 8x2
// image instance, plus one full default-size frame on a second instance.
`timescale 1ns/1ps
module tb_bin_frame_reader;
  localparam int SW = 8, SH = 2, SA = 4;
  localparam int SNPIX = SW * SH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // small instance with a registered-read RAM model
  logic          s_rst = 1'b1, s_ctrl = 1'b0, s_ready = 1'b0, s_bin = 1'b0;
  logic          s_valid;
  logic [SA-1:0] s_addr;
  logic [7:0]    s_data;
  logic [1:0]    s_led;
  logic          s_mem [SNPIX];

  bin_frame_reader #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(SA)) dut_s (
    .rdr_clk(clk), .rdr_rst(s_rst), .rdr_ctrl(s_ctrl),
    .pixel_address(s_addr), .bin_data(s_bin),
    .byte_data(s_data), .byte_valid(s_valid), .byte_ready(s_ready),
    .condition_led(s_led)
  );

  always @(posedge clk) s_bin <= s_mem[s_addr];

  // full-size instance; RAM pixel value is address bit 3
  logic        b_rst = 1'b1, b_ctrl = 1'b0, b_ready = 1'b1, b_bin = 1'b0;
  logic        b_valid;
  logic [15:0] b_addr;
  logic [7:0]  b_data;
  logic [1:0]  b_led;

  bin_frame_reader dut_b (
    .rdr_clk(clk), .rdr_rst(b_rst), .rdr_ctrl(b_ctrl),
    .pixel_address(b_addr), .bin_data(b_bin),
    .byte_data(b_data), .byte_valid(b_valid), .byte_ready(b_ready),
    .condition_led(b_led)
  );

  always @(posedge clk) b_bin <= b_addr[3];

  // reference models: byte i holds pixels 8i..8i+7, pixel 8i in bit 7
  function automatic logic [7:0] s_model_byte(input int i);
    logic [7:0] b;
    b = 8'd0;
    for (int k = 0; k < 8; k++) b[7-k] = s_mem[8*i + k];
    return b;
  endfunction

  function automatic logic [7:0] b_model_byte(input int i);
    logic [7:0] b;
    int p;
    b = 8'd0;
    for (int k = 0; k < 8; k++) begin
      p = 8*i + k;
      b[7-k] = ((p / 8) % 2) == 1;
    end
    return b;
  endfunction

  // monitors sample between the driving negedge and the next posedge
  logic [7:0]    got_q[$];
  logic          pend = 1'b0;
  logic [7:0]    pend_data;
  logic [SA-1:0] pend_addr;

  always @(negedge clk) begin
    #2;
    if (pend) begin
      check("hold_valid", s_valid, 1);
      check("hold_data", s_data, pend_data);
      check("hold_addr", s_addr, pend_addr);
    end
    pend = 1'b0;
    if (!s_rst && s_valid) begin
      if (s_ready) got_q.push_back(s_data);
      else begin
        pend = 1'b1;
        pend_data = s_data;
        pend_addr = s_addr;
      end
    end
  end

  int b_count = 0;
  int b_bad = 0;
  always @(negedge clk) begin
    #2;
    if (!b_rst && b_valid && b_ready) begin
      if (b_data !== b_model_byte(b_count)) b_bad++;
      b_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic s_load(input logic [15:0] bits);
    for (int a = 0; a < SNPIX; a++) s_mem[a] = bits[15-a];
  endtask

  task automatic s_pulse();
    s_ctrl = 1'b1;
    tick(1);
    s_ctrl = 1'b0;
  endtask

  task automatic s_wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (s_led !== 2'b10 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, s_led, 2'b10);
  endtask

  typedef struct {
    logic [15:0] bits;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs[6];

  task automatic small_tests();
    int act;
    logic [15:0] rbits;
    vecs[0] = '{16'hA53C, 8'hA5, 8'h3C};
    vecs[1] = '{16'h0000, 8'h00, 8'h00};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[3] = '{16'h8001, 8'h80, 8'h01};
    vecs[4] = '{16'h1234, 8'h12, 8'h34};
    vecs[5] = '{16'h5AC3, 8'h5A, 8'hC3};

    // reset and quiet period
    s_rst = 1'b1; s_ctrl = 1'b0; s_ready = 1'b0;
    tick(3);
    check("rst_valid", s_valid, 0);
    check("rst_led", s_led, 2'b00);
    check("rst_addr", s_addr, 0);
    check("rst_data", s_data, 0);
    s_rst = 1'b0;
    act = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      if (s_valid || s_led != 2'b00 || s_addr != '0) act++;
    end
    check("rst_quiet", act, 0);
    check("rst_no_bytes", got_q.size(), 0);

    // pattern pack with cycle-exact timing, ready tied high
    s_load(16'hA53C);
    s_ready = 1'b1;
    got_q.delete();
    s_ctrl = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick(1);
      s_ctrl = 1'b0;
      check($sformatf("pp_addr_t%0d", t), s_addr, (t <= 8) ? t - 1 : 7);
      check($sformatf("pp_valid_t%0d", t), s_valid, 0);
      check($sformatf("pp_led_t%0d", t), s_led, 2'b01);
    end
    tick(1);
    check("pp_valid_t10", s_valid, 1);
    check("pp_data_t10", s_data, 8'hA5);
    tick(1);
    check("pp_addr_t11", s_addr, 8);
    check("pp_valid_t11", s_valid, 0);
    tick(9);
    check("pp_valid_t20", s_valid, 1);
    check("pp_data_t20", s_data, 8'h3C);
    check("pp_addr_t20", s_addr, 15);
    tick(1);
    check("pp_valid_t21", s_valid, 0);
    check("pp_led_t21", s_led, 2'b10);
    check("pp_addr_done", s_addr, 15);
    check("pp_count", got_q.size(), 2);
    check("pp_byte0", got_q[0], 8'hA5);
    check("pp_byte1", got_q[1], 8'h3C);

    // table of patterns, each restarted from DONE
    for (int v = 0; v < 6; v++) begin
      s_load(vecs[v].bits);
      s_ready = 1'b1;
      got_q.delete();
      s_pulse();
      s_wait_done($sformatf("tbl%0d_done", v), 60);
      check($sformatf("tbl%0d_count", v), got_q.size(), 2);
      check($sformatf("tbl%0d_byte0", v), got_q[0], vecs[v].b0);
      check($sformatf("tbl%0d_byte1", v), got_q[1], vecs[v].b1);
    end

    // backpressure on the first byte
    s_load(16'hA53C);
    s_ready = 1'b0;
    got_q.delete();
    s_pulse();
    tick(9);
    check("bp_valid", s_valid, 1);
    check("bp_data", s_data, 8'hA5);
    check("bp_addr", s_addr, 7);
    for (int t = 0; t < 5; t++) begin
      tick(1);
      check($sformatf("bp_stall%0d_valid", t), s_valid, 1);
      check($sformatf("bp_stall%0d_addr", t), s_addr, 7);
    end
    s_ready = 1'b1;
    tick(1);
    check("bp_after_valid", s_valid, 0);
    check("bp_after_addr", s_addr, 8);
    s_wait_done("bp_done", 40);
    check("bp_count", got_q.size(), 2);
    check("bp_byte0", got_q[0], 8'hA5);
    check("bp_byte1", got_q[1], 8'h3C);

    // held start, ignored busy edge, restart from DONE
    s_load(16'h5AC3);
    s_ready = 1'b1;
    got_q.delete();
    s_ctrl = 1'b1;
    tick(10);
    s_ctrl = 1'b0;
    tick(2);
    s_pulse();
    s_wait_done("held_done", 60);
    check("held_count", got_q.size(), 2);
    tick(15);
    check("held_count_later", got_q.size(), 2);
    check("held_led_later", s_led, 2'b10);
    s_pulse();
    s_wait_done("held_redo_done", 60);
    check("held_redo_count", got_q.size(), 4);
    check("held_redo_byte0", got_q[2], 8'h5A);
    check("held_redo_byte1", got_q[3], 8'hC3);

    // start edge coinciding with the final handshake is ignored
    got_q.delete();
    s_pulse();
    tick(19);
    check("coinc_valid", s_valid, 1);
    s_ctrl = 1'b1;
    tick(1);
    s_ctrl = 1'b0;
    check("coinc_led", s_led, 2'b10);
    check("coinc_valid_off", s_valid, 0);
    tick(15);
    check("coinc_count", got_q.size(), 2);
    check("coinc_led_later", s_led, 2'b10);

    // reset while byte 1 waits in SEND
    s_load(16'h1234);
    s_ready = 1'b1;
    got_q.delete();
    s_pulse();
    tick(9);
    check("mrst_first_valid", s_valid, 1);
    tick(1);
    s_ready = 1'b0;
    tick(9);
    check("mrst_send_valid", s_valid, 1);
    check("mrst_send_data", s_data, 8'h34);
    s_rst = 1'b1;
    tick(1);
    check("mrst_valid", s_valid, 0);
    check("mrst_led", s_led, 2'b00);
    check("mrst_addr", s_addr, 0);
    s_rst = 1'b0;
    s_ready = 1'b1;
    act = 0;
    for (int t = 0; t < 15; t++) begin
      tick(1);
      if (s_valid || s_led != 2'b00) act++;
    end
    check("mrst_quiet", act, 0);
    check("mrst_count", got_q.size(), 1);
    s_pulse();
    check("mrst_restart_addr", s_addr, 0);
    check("mrst_restart_led", s_led, 2'b01);
    s_wait_done("mrst_done", 60);
    check("mrst_total", got_q.size(), 3);
    check("mrst_byte0", got_q[1], 8'h12);
    check("mrst_byte1", got_q[2], 8'h34);

    // random images with random backpressure against the packing model
    for (int r = 0; r < 20; r++) begin
      rbits = 16'($urandom);
      s_load(rbits);
      got_q.delete();
      s_ready = 1'($urandom_range(0, 1));
      s_pulse();
      for (int n = 0; n < 200 && s_led !== 2'b10; n++) begin
        s_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
      check($sformatf("rnd%0d_done", r), s_led, 2'b10);
      check($sformatf("rnd%0d_count", r), got_q.size(), 2);
      for (int i = 0; i < 2; i++)
        check($sformatf("rnd%0d_byte%0d", r, i), got_q[i], s_model_byte(i));
    end
  endtask

  task automatic big_test();
    int n;
    b_rst = 1'b1; b_ctrl = 1'b0; b_ready = 1'b1;
    tick(3);
    b_rst = 1'b0;
    check("full_rst_led", b_led, 2'b00);
    b_ctrl = 1'b1;
    tick(1);
    b_ctrl = 1'b0;
    check("full_first_addr", b_addr, 0);
    check("full_busy_led", b_led, 2'b01);
    n = 0;
    while (b_led !== 2'b10 && n < 82500) begin
      tick(1);
      n++;
    end
    check("full_done", b_led, 2'b10);
    check("full_count", b_count, 8192);
    check("full_bad_bytes", b_bad, 0);
    check("full_last_addr", b_addr, 16'hFFFF);
    check("full_valid_off", b_valid, 0);
  endtask

  initial begin
    tick(1);
    fork
      small_tests();
      big_test();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
